// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing constants and pointer/count types for the 256 x 8 FIFO controller.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 8;
    localparam int FIFO_DEPTH  = 256;

    // The extra MSB is the wrap bit that tells full from empty.
    typedef logic [FIFO_ADDR_W:0] fifo_ptr_t;
    typedef logic [FIFO_ADDR_W:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer register with increment and synchronous flush.
module fifo_ptr #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       inc,
    output logic [W:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (flush)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + (W+1)'(1);
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer, occupancy, flag and sticky-error controller for a 256 x 8 FIFO.
// Optional registered almost_full/almost_empty flags under FIFO_ALMOST_FLAGS_EN.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = 240,
    parameter int AE_LEVEL = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              wr_sel_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf,
    output logic              almost_full,
    output logic              almost_empty
);

    if (DEPTH != (1 << ADDR_W) || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_cfg
        $error("fifo_ptr_ctrl: DEPTH must be 2**ADDR_W and thresholds must not exceed DEPTH");
    end

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            wr_acc;
    logic            rd_acc;

    fifo_ptr #(.W(ADDR_W)) u_wr (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(ADDR_W)) u_rd (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    // Flags come from the registered pointers only; no lookahead on same-cycle reads.
    always_comb begin
        empty     = wr_ptr == rd_ptr;
        full      = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        count     = wr_ptr - rd_ptr;
        wr_addr   = wr_ptr[ADDR_W-1:0];
        rd_addr   = rd_ptr[ADDR_W-1:0];
        wr_acc    = wr_req && !full && !flush;
        rd_acc    = rd_req && !empty && !flush;
        wr_sel_en = wr_acc;
        rd_valid  = rd_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (flush) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_req && full)
                ovf <= 1'b1;
            if (rd_req && empty)
                udf <= 1'b1;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    logic [ADDR_W:0] next_cnt;

    // A flush drives next_cnt to zero, which yields almost_empty=1 and almost_full=0.
    always_comb begin
        next_cnt = flush ? '0 : count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= next_cnt >= (ADDR_W+1)'(AF_LEVEL);
            almost_empty <= next_cnt <= (ADDR_W+1)'(AE_LEVEL);
        end
    end
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Pointer, occupancy and flag controller for the 256 x 8-bit FIFO. It sits directly upstream of the 8-to-256 write-select decoder. It drives the decoder's 8-bit address (wr_addr) and enable (wr_sel_en), and supplies rd_addr to the read-side 256:1 mux. It owns all sequential state of the FIFO: pointers, count, flags and error stickies. Storage itself sits outside this block.

Parameters:
ADDR_W, 8, pointer/address width; matches the 8-bit decoder input.
DEPTH, 256, number of words; must equal 2**ADDR_W.
AF_LEVEL, 240, almost-full threshold in words (used only with optional feature).
AE_LEVEL, 16, almost-empty threshold in words (used only with optional feature).

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of pointers, count and stickies.
wr_req  input  1  producer write request.
rd_req  input  1  consumer read request.
wr_sel_en  output  1  decoder enable; high on the cycle a write is accepted.
wr_addr  output  ADDR_W  decoder address = write pointer low bits.
rd_addr  output  ADDR_W  read mux select = read pointer low bits.
rd_valid  output  1  high on the cycle a read is accepted.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  ADDR_W+1  occupancy, 0..256.
ovf  output  1  sticky: write requested while full.
udf  output  1  sticky: read requested while empty.
almost_full  output  1  optional feature only.
almost_empty  output  1  optional feature only.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, ovf=0, udf=0. Outputs: empty=1, full=0, wr_addr=0, rd_addr=0, almost_empty=1, almost_full=0.
- Reset is asynchronous on assertion. Release is used synchronously; the block has no release synchroniser.
- Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Write accept: wr_acc = wr_req & ~full & ~flush, combinational.
  - wr_sel_en = wr_acc, so the decoder selects row wr_addr that same cycle and storage latches on that clk edge.
  - wr_ptr increments on the edge.
- Read accept: rd_acc = rd_req & ~empty & ~flush, combinational.
  - rd_valid = rd_acc; data at rd_addr is valid that cycle.
  - rd_ptr increments on the edge.
- Flag behaviour follows the registered pointers; there is no lookahead. A read accepted while full does not enable a same-cycle write.
- Simultaneous wr_acc & rd_acc: both pointers advance and count is unchanged.
- Empty with wr_req & rd_req: only the write is accepted; count goes 0 -> 1; udf sets.
- Full with both requests: only the read is accepted; count goes 256 -> 255; ovf sets.
- Wrap-around: the low pointer bits roll over from 255 to 0 and the MSB toggles; addresses stay continuous.
- Stickies:
  - ovf sets on wr_req & full; udf sets on rd_req & empty.
  - Both hold until flush or reset.
  - Requests blocked by flush do not set them.
- flush: on the next edge, pointers=0, count=0, ovf=udf=0. It has priority over all requests in the same cycle, and wr_sel_en and rd_valid are forced low.
- Outputs are derived from registers only, except wr_sel_en and rd_valid, which are combinational from requests.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined:
  - almost_full and almost_empty are registered.
  - almost_full = (next count >= AF_LEVEL); almost_empty = (next count <= AE_LEVEL).
  - Both update on the same edge as count.
  - Reset values: almost_full=0, almost_empty=1. Flush sets almost_empty=1 and almost_full=0.
- Undefined: both ports remain and are tied to 0; no threshold logic is generated.

Decomposition:
- Package fifo_pkg holds:
  - constants FIFO_ADDR_W=8 and FIFO_DEPTH=256;
  - typedefs for the ADDR_W+1 pointer and the count.
- Optional sub-module fifo_ptr: one parameterised wrap-bit pointer register with increment and flush. It is instantiated twice, once for write and once for read.
- Flag and sticky logic stays in the top module.

Test Plan:
- Reset, then 3 writes -> wr_sel_en high 3 cycles with wr_addr 0,1,2; count=3; empty=0.
- 256 writes from empty -> full=1 after the 256th edge; a further wr_req gives wr_sel_en=0 and ovf=1; wr_addr=0 with the wrap bit set.
- Full with wr_req and rd_req in one cycle -> rd_valid=1, rd_addr=0, wr_sel_en=0; count=255.
- Count=10 with wr_req and rd_req held for 300 cycles -> count stays 10; both addresses wrap past 255 to 0; no stickies.
- Empty with rd_req -> rd_valid=0, udf=1; then flush -> udf=0 and count=0; rst_n low mid-burst -> outputs immediately return to reset values without waiting for clk.
- With FIFO_ALMOST_FLAGS_EN: fill to 239 -> almost_full=0; the 240th write -> almost_full=1; drain to 16 -> almost_empty=1.
